// File: rtl/pc_ret_stack_if.sv
// Call/return bus between the control unit and the return-address stack.
// DEPTH must match the pc_ret_stack instance so that level is sized correctly.
interface pc_ret_stack_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [9:0]       pc_count;
  logic [9:0]       ret_addr;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             err;

  // Control unit side: issues CALL/RET strobes and the current PC.
  modport master (
    output push, pop, pc_count,
    input  ret_addr, full, empty, level, err
  );

  // Stack side.
  modport slave (
    input  push, pop, pc_count,
    output ret_addr, full, empty, level, err
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack for the MCU program counter.
// CALL stores pc_count+1; RET pops, with ret_addr already showing the popped entry.
// Build option: define RAS_ERR_STICKY_EN to make err sticky until rst,
// otherwise err is a one-cycle pulse after each overflow/underflow.
module pc_ret_stack #(
  parameter int unsigned DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  pc_ret_stack_if.slave bus
);
  localparam int unsigned AW    = 10;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [AW-1:0]    mem [DEPTH];
  logic [LVL_W-1:0] sp_q, sp_nxt;
  logic [AW-1:0]    top_q, top_nxt;
  logic             full_q, empty_q, err_q, err_nxt;
  logic             is_full, is_empty;
  logic [AW-1:0]    push_val;
  logic             wr_en, err_evt;
  logic [PTR_W-1:0] wr_idx;

  // Next stack pointer, array write and next top-of-stack shadow.
  always_comb begin
    push_val = bus.pc_count + AW'(1);
    is_full  = (sp_q == LVL_W'(DEPTH));
    is_empty = (sp_q == '0);
    sp_nxt   = sp_q;
    top_nxt  = top_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    err_evt  = 1'b0;
    if (bus.push && bus.pop) begin
      // Replace top; on an empty stack the push still happens but flags underflow.
      wr_en   = 1'b1;
      top_nxt = push_val;
      if (is_empty) begin
        wr_idx  = '0;
        sp_nxt  = LVL_W'(1);
        err_evt = 1'b1;
      end else begin
        wr_idx = PTR_W'(sp_q - LVL_W'(1));
      end
    end else if (bus.push) begin
      if (is_full) begin
        err_evt = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = PTR_W'(sp_q);
        sp_nxt  = sp_q + LVL_W'(1);
        top_nxt = push_val;
      end
    end else if (bus.pop) begin
      if (is_empty) begin
        err_evt = 1'b1;
      end else begin
        sp_nxt  = sp_q - LVL_W'(1);
        top_nxt = (sp_q >= LVL_W'(2)) ? mem[PTR_W'(sp_q - LVL_W'(2))] : '0;
      end
    end
`ifdef RAS_ERR_STICKY_EN
    err_nxt = err_q | err_evt;
`else
    err_nxt = err_evt;
`endif
  end

  // Return-address storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= push_val;
    end
  end

  // Pointer, registered top-of-stack copy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      top_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      sp_q    <= sp_nxt;
      top_q   <= top_nxt;
      full_q  <= (sp_nxt == LVL_W'(DEPTH));
      empty_q <= (sp_nxt == '0);
      err_q   <= err_nxt;
    end
  end

  assign bus.ret_addr = top_q;
  assign bus.level    = sp_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_pc_ret_stack.sv
// Scoreboard bench for pc_ret_stack: a queue-based stack model produces the
// expected outputs per cycle, a separate monitor compares them after each edge.
module tb_pc_ret_stack;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [9:0]       ret;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic             err;
  } exp_t;

  logic clk;
  logic rst;
  pc_ret_stack_if #(.DEPTH(DEPTH)) bus ();

  pc_ret_stack #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   stk[$];
  bit   err_m;
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stack semantics on a queue, evaluated once per edge.
  task automatic model_step(input bit r, input bit pu, input bit po, input int pc);
    bit   ev;
    int   val;
    exp_t e;
    val = (pc + 1) % 1024;
    ev  = 1'b0;
    if (r) begin
      stk.delete();
      err_m = 1'b0;
    end else begin
      if (pu && po) begin
        if (stk.size() == 0) begin
          stk.push_back(val);
          ev = 1'b1;
        end else begin
          stk[stk.size()-1] = val;
        end
      end else if (pu) begin
        if (stk.size() == DEPTH) ev = 1'b1;
        else stk.push_back(val);
      end else if (po) begin
        if (stk.size() == 0) ev = 1'b1;
        else void'(stk.pop_back());
      end
`ifdef RAS_ERR_STICKY_EN
      err_m = err_m | ev;
`else
      err_m = ev;
`endif
    end
    e.ret   = (stk.size() != 0) ? 10'(stk[stk.size()-1]) : 10'h000;
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    e.level = LVL_W'(stk.size());
    e.err   = err_m;
    exp_q.push_back(e);
  endtask

  // Apply one cycle of stimulus and record the expected post-edge outputs.
  task automatic step(input bit r, input bit pu, input bit po, input int pc);
    @(negedge clk);
    rst          = r;
    bus.push     = pu;
    bus.pop      = po;
    bus.pc_count = 10'(pc);
    @(posedge clk);
    model_step(r, pu, po, pc);
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ret_addr", int'(bus.ret_addr), int'(e.ret));
      check("full",     int'(bus.full),     int'(e.full));
      check("empty",    int'(bus.empty),    int'(e.empty));
      check("level",    int'(bus.level),    int'(e.level));
      check("err",      int'(bus.err),      int'(e.err));
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    err_m        = 1'b0;
    rst          = 1'b1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.pc_count = '0;

    // Reset and idle.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Push 0x010, 0x020, 0x3FF (wraps), then pop three times.
    step(0, 1, 0, 'h010);
    step(0, 1, 0, 'h020);
    step(0, 1, 0, 'h3FF);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Overflow: nine pushes into a depth-8 stack, then idle to see err behaviour.
    for (int i = 0; i < 9; i++) step(0, 1, 0, i);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Full, simultaneous push+pop: replace top, no error.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 'h40 + i);
    step(0, 1, 1, 'h100);
    step(0, 0, 0, 0);

    // Underflow then push+pop on empty.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 'h1A0);
    step(0, 0, 0, 0);

    // Reset wins over push mid-sequence.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 'h200 + i);
    step(1, 1, 0, 'h300);
    step(0, 0, 0, 0);

    // Randomised traffic with phases biased toward filling or draining.
    for (int ph = 0; ph < 40; ph++) begin
      int push_pct;
      push_pct = (ph % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 40; i++) begin
        bit r, pu, po;
        r  = ($urandom_range(0, 199) == 0);
        pu = ($urandom_range(0, 99) < push_pct);
        po = ($urandom_range(0, 99) < (100 - push_pct));
        step(r, pu, po, int'($urandom_range(0, 1023)));
      end
    end

    step(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
